// File: rtl/execute_stage_p.sv
// Execute pipeline stage: operand selection, single-cycle ALU, multi-cycle shift-add multiply,
// and registered result/flags/store-data/destination with valid/stall/flush control.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready = !stall && FSM idle
//   stall, flush      downstream hold request, pipeline squash
//   pc, a, b, imm, rd instruction operands and destination register
//   aluop, aluin1/2   operation and operand selects
//   out_valid         output registers hold a valid result
//   aluout, bout      registered result and store data (copy of b)
//   rdout             registered destination register
//   zero, pos         registered flags: result == 0, result signed > 0
//   busy              multiply in progress
module execute_stage_p #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned PC_INC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   imm,
    input  logic [RADDR_W-1:0] rd,
    input  logic [3:0]         aluop,
    input  logic               aluin1,
    input  logic [1:0]         aluin2,
    output logic               out_valid,
    output logic [WIDTH-1:0]   aluout,
    output logic [WIDTH-1:0]   bout,
    output logic [RADDR_W-1:0] rdout,
    output logic               zero,
    output logic               pos,
    output logic               busy
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam logic [3:0]  OpMul = 4'd10;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q;
    logic [SH_W-1:0]      count_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [WIDTH-1:0]     mul_st_q;
    logic [RADDR_W-1:0]   mul_rd_q;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     aluout_q;
    logic [WIDTH-1:0]     bout_q;
    logic [RADDR_W-1:0]   rdout_q;
    logic                 zero_q;
    logic                 pos_q;

    logic [WIDTH-1:0]     op1;
    logic [WIDTH-1:0]     op2;
    logic [SH_W-1:0]      sh;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]     load_val;
    logic                 accept;

    assign in_ready = !stall && (state_q == StIdle);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state_q != StIdle);

    always_comb begin
        op1 = aluin1 ? a : pc;
        op2 = '0;
        case (aluin2)
            2'd0:    op2 = b;
            2'd1:    op2 = WIDTH'(PC_INC);
            2'd2:    op2 = imm;
            default: op2 = '0;
        endcase
    end

    assign sh = op2[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (aluop)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 & op2;
            4'd3:    alu_res = op1 | op2;
            4'd4:    alu_res = op1 ^ op2;
            4'd5:    alu_res = op1 << sh;
            4'd6:    alu_res = op1 >> sh;
            4'd7:    alu_res = $unsigned($signed(op1) >>> sh);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'd9:    alu_res = op2;
            default: alu_res = '0;
        endcase
    end

    // One partial product per cycle, LSB of the multiplier first.
    assign acc_next = mul_a_q[count_q] ? (acc_q + (mul_b_q << count_q)) : acc_q;

    // Outputs load either from the ALU (idle accept) or the multiply accumulator (done).
    assign load_val = (state_q == StDone) ? acc_q : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_st_q    <= '0;
            mul_rd_q    <= '0;
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            bout_q      <= '0;
            rdout_q     <= '0;
            zero_q      <= 1'b0;
            pos_q       <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (aluop == OpMul) begin
                            mul_a_q     <= op1;
                            mul_b_q     <= op2;
                            mul_st_q    <= b;
                            mul_rd_q    <= rd;
                            count_q     <= '0;
                            acc_q       <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= StMul;
                        end else begin
                            aluout_q    <= load_val;
                            zero_q      <= (load_val == '0);
                            pos_q       <= !load_val[WIDTH-1] && (load_val != '0);
                            bout_q      <= b;
                            rdout_q     <= rd;
                            out_valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StMul: begin
                    acc_q   <= acc_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == SH_W'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!stall) begin
                        aluout_q    <= load_val;
                        zero_q      <= (load_val == '0);
                        pos_q       <= !load_val[WIDTH-1] && (load_val != '0);
                        bout_q      <= mul_st_q;
                        rdout_q     <= mul_rd_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign aluout    = aluout_q;
    assign bout      = bout_q;
    assign rdout     = rdout_q;
    assign zero      = zero_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_execute_stage_p.sv
module tb_execute_stage_p;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic [W-1:0]  pc, a, b, imm;
    logic [3:0]    rd;
    logic [3:0]    aluop;
    logic          aluin1;
    logic [1:0]    aluin2;
    logic          out_valid;
    logic [W-1:0]  aluout, bout;
    logic [3:0]    rdout;
    logic          zero, pos, busy;

    int vectors = 0;
    int miscompares = 0;

    execute_stage_p #(.WIDTH(16), .RADDR_W(4), .PC_INC(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .pc(pc), .a(a), .b(b), .imm(imm), .rd(rd),
        .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2), .out_valid(out_valid),
        .aluout(aluout), .bout(bout), .rdout(rdout), .zero(zero), .pos(pos), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: result of an instruction from the operation table, plain integer arithmetic.
    function automatic logic [W-1:0] ref_result(input int op, input logic s1, input logic [1:0] s2,
                                                input logic [W-1:0] p, x, y, im);
        longint o1, o2, r;
        int sh;
        o1 = s1 ? longint'(x) : longint'(p);
        case (s2)
            2'd0:    o2 = longint'(y);
            2'd1:    o2 = 2;
            2'd2:    o2 = longint'(im);
            default: o2 = 0;
        endcase
        sh = int'(o2 % 16);
        case (op)
            0:       r = (o1 + o2) % 65536;
            1:       r = (o1 - o2 + 65536) % 65536;
            2:       r = o1 & o2;
            3:       r = o1 | o2;
            4:       r = o1 ^ o2;
            5:       r = (o1 * (64'd1 << sh)) % 65536;
            6:       r = o1 / (64'd1 << sh);
            7:       r = ((o1 >= 32768 ? o1 - 65536 : o1) >>> sh) & 65535;
            8:       r = ((o1 >= 32768 ? o1 - 65536 : o1) < (o2 >= 32768 ? o2 - 65536 : o2)) ? 1 : 0;
            9:       r = o2;
            10:      r = (o1 * o2) % 65536;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        pc = '0; a = '0; b = '0; imm = '0; rd = '0; aluop = '0; aluin1 = 1'b0; aluin2 = '0;
    endtask

    // Called at a negedge; presents one instruction and returns at the next negedge.
    task automatic issue(input logic [3:0] op, input logic s1, input logic [1:0] s2,
                         input logic [W-1:0] p, x, y, im, input logic [3:0] r);
        aluop = op; aluin1 = s1; aluin2 = s2; pc = p; a = x; b = y; imm = im; rd = r;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, aluout, bout, rdout, zero, pos, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ov=%b alu=%h b=%h rd=%h z=%b p=%b busy=%b want all 0",
                     out_valid, aluout, bout, rdout, zero, pos, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        issue(4'd0, 1'b1, 2'd2, 16'h0, 16'h7FFF, 16'h0, 16'h0001, 4'd1);
        vectors++;
        if ({out_valid, aluout, zero, pos} !== {1'b1, 16'h8000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_overflow: got ov=%b alu=%h z=%b p=%b want 1 8000 0 0",
                     out_valid, aluout, zero, pos);
        end
        issue(4'd1, 1'b1, 2'd0, 16'h0, 16'h0005, 16'h0005, 16'h0, 4'd2);
        vectors++;
        if ({out_valid, aluout, zero, pos} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_zero: got ov=%b alu=%h z=%b p=%b want 1 0000 1 0",
                     out_valid, aluout, zero, pos);
        end
    endtask

    task automatic test_pc_inc();
        issue(4'd0, 1'b0, 2'd1, 16'h00FE, 16'h0, 16'h1234, 16'h0, 4'd7);
        vectors++;
        if ({out_valid, aluout, zero, pos, bout, rdout} !==
            {1'b1, 16'h0100, 1'b0, 1'b1, 16'h1234, 4'd7}) begin
            miscompares++;
            $display("FAIL pc_inc: got ov=%b alu=%h z=%b p=%b b=%h rd=%0d want 1 0100 0 1 1234 7",
                     out_valid, aluout, zero, pos, bout, rdout);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, aluout} !== {1'b0, 16'h0100}) begin
            miscompares++;
            $display("FAIL idle_drop_valid: got ov=%b alu=%h want 0 0100", out_valid, aluout);
        end
    endtask

    task automatic test_mul_sra();
        int cyc = 0;
        int not_ready = 0;
        issue(4'd10, 1'b1, 2'd0, 16'h0, 16'h0003, 16'hFFFF, 16'h0, 4'd9);
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (in_ready === 1'b0 && busy === 1'b1) not_ready++;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 17 || not_ready != 17) begin
            miscompares++;
            $display("FAIL mul_latency: got cycles=%0d not_ready=%0d want 17 17", cyc, not_ready);
        end
        vectors++;
        if ({out_valid, aluout, bout, rdout, busy} !== {1'b1, 16'hFFFD, 16'hFFFF, 4'd9, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_result: got ov=%b alu=%h b=%h rd=%0d busy=%b want 1 FFFD FFFF 9 0",
                     out_valid, aluout, bout, rdout, busy);
        end
        issue(4'd7, 1'b1, 2'd2, 16'h0, 16'h8000, 16'h0, 16'h000F, 4'd3);
        vectors++;
        if ({out_valid, aluout, zero, pos} !== {1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sra: got ov=%b alu=%h z=%b p=%b want 1 FFFF 0 0",
                     out_valid, aluout, zero, pos);
        end
    endtask

    task automatic test_stall();
        issue(4'd9, 1'b1, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0042, 4'd4);
        stall = 1'b1;
        aluop = 4'd0; aluin1 = 1'b1; aluin2 = 2'd0; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, aluout, in_ready, rdout} !== {1'b1, 16'h0042, 1'b0, 4'd4}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got ov=%b alu=%h rdy=%b rd=%0d want 1 0042 0 4",
                         i, out_valid, aluout, in_ready, rdout);
            end
        end
        stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, aluout} !== {1'b0, 16'h0042}) begin
            miscompares++;
            $display("FAIL stall_release: got ov=%b alu=%h want 0 0042", out_valid, aluout);
        end
        // Stall while the multiply result is waiting to be written out.
        issue(4'd10, 1'b1, 2'd2, 16'h0, 16'h0007, 16'h0ABC, 16'h0006, 4'd5);
        repeat (16) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, busy, aluout} !== {1'b0, 1'b1, 16'h0042}) begin
                miscompares++;
                $display("FAIL stall_done[%0d]: got ov=%b busy=%b alu=%h want 0 1 0042",
                         i, out_valid, busy, aluout);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, busy, aluout, bout, rdout} !== {1'b1, 1'b0, 16'd42, 16'h0ABC, 4'd5}) begin
            miscompares++;
            $display("FAIL stall_done_release: got ov=%b busy=%b alu=%h b=%h rd=%0d want 1 0 002A 0ABC 5",
                     out_valid, busy, aluout, bout, rdout);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        issue(4'd10, 1'b1, 2'd0, 16'h0, 16'h0003, 16'h0005, 16'h0, 4'd6);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL flush_mul: got busy=%b ov=%b rdy=%b want 0 0 1", busy, out_valid, in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_mul_no_result: got %0d valid cycles want 0", seen);
        end
        issue(4'd0, 1'b1, 2'd2, 16'h0, 16'h0001, 16'h0, 16'h0001, 4'd2);
        aluop = 4'd0; aluin1 = 1'b1; aluin2 = 2'd2; a = 16'h0064; imm = 16'h0; in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if ({out_valid, aluout, busy} !== {1'b0, 16'h0002, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_in_valid: got ov=%b alu=%h busy=%b want 0 0002 0",
                     out_valid, aluout, busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        issue(4'd10, 1'b1, 2'd0, 16'h0, 16'h0003, 16'h0005, 16'h0, 4'd8);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, aluout, bout, rdout, zero, pos, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_mul: got ov=%b alu=%h b=%h rd=%h z=%b p=%b busy=%b want all 0",
                     out_valid, aluout, bout, rdout, zero, pos, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_mid_mul_release: got rdy=%b busy=%b ov=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    // Back-to-back random instructions, results checked against ref_result.
    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op, r;
            logic         s1;
            logic [1:0]   s2;
            logic [W-1:0] p, x, y, im, exp_v;
            int           cyc;
            op = 4'($urandom_range(0, 15));
            s1 = 1'($urandom_range(0, 1));
            s2 = 2'($urandom_range(0, 3));
            p  = 16'($urandom); x = 16'($urandom); y = 16'($urandom); im = 16'($urandom);
            r  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) x = 16'h0;
            exp_v = ref_result(int'(op), s1, s2, p, x, y, im);
            issue(op, s1, s2, p, x, y, im, r);
            if (op == 4'd10) begin
                cyc = 0;
                while (out_valid !== 1'b1 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                end
                vectors++;
                if (cyc != 17) begin
                    miscompares++;
                    $display("FAIL rand_mul_latency[%0d]: got %0d want 17", i, cyc);
                end
            end
            vectors++;
            if ({out_valid, aluout, zero, pos, bout, rdout} !==
                {1'b1, exp_v, exp_v == 16'h0, !exp_v[W-1] && exp_v != 16'h0, y, r}) begin
                miscompares++;
                $display("FAIL rand[%0d] op=%0d: got ov=%b alu=%h z=%b p=%b b=%h rd=%0d want alu=%h b=%h rd=%0d",
                         i, op, out_valid, aluout, zero, pos, bout, rdout, exp_v, y, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_pc_inc();
        test_mul_sra();
        test_stall();
        test_reset_mid_mul();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/execute_stage_p.md
Name: execute_stage_p

Overview:
- Parametrised execute pipeline stage for the WIDTH-bit processor, between decode/register-read and memory.
- Selects ALU operands (PC or A; B, PC increment, immediate or zero), computes single-cycle ALU ops and a multi-cycle shift-add multiply.
- Registers result, flags, B pass-through and destination register with valid/stall/flush pipeline control.

Parameters:
- WIDTH, 16, datapath width in bits (>=4, power of 2).
- RADDR_W, 4, destination register index width.
- PC_INC, 2, constant on operand-2 select 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage accepts this cycle; combinational: !stall && state==IDLE.
- stall  in  1  downstream cannot accept; output registers hold.
- flush  in  1  squash: drop in-flight and presented instruction.
- pc  in  WIDTH  instruction PC.
- a  in  WIDTH  register operand A.
- b  in  WIDTH  register operand B.
- imm  in  WIDTH  sign-extended immediate.
- rd  in  RADDR_W  destination register.
- aluop  in  4  operation select.
- aluin1  in  1  operand 1: 0=pc, 1=a.
- aluin2  in  2  operand 2: 0=b, 1=PC_INC, 2=imm, 3=0.
- out_valid  out  1  output registers hold a valid result.
- aluout  out  WIDTH  registered result.
- bout  out  WIDTH  registered copy of b (store data).
- rdout  out  RADDR_W  registered rd.
- zero  out  1  registered: aluout==0.
- pos  out  1  registered: aluout signed >0.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (rst=0, async): all outputs 0, out_valid=0, busy=0, FSM=IDLE, multiply regs cleared. Takes effect mid-multiply; operation lost.
- aluop: 0 ADD, 1 SUB (op1-op2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 PASS op2, 10 MUL, 11-15 result 0.
- Shifts use op2[log2(WIDTH)-1:0]; upper bits ignored.
- Add/sub/mul are modulo 2^WIDTH; MUL keeps low WIDTH bits; no overflow flag.
- pos = !aluout[WIDTH-1] && aluout!=0.
- Accept = in_valid && in_ready && !flush.
- Single-cycle ops: on accept, next edge loads aluout/zero/pos/bout/rdout; out_valid=1. Latency 1.
- No accept and no stall: out_valid<=0 next edge; data regs hold.
- stall=1: all output registers hold, including out_valid; in_ready=0.
- FSM IDLE/MUL/DONE:
  - IDLE: accept with MUL latches op1, op2, b, rd; count=0; ->MUL; out_valid<=0; busy=1.
  - MUL: per cycle, add op2<<count to acc if op1[count]; count++. After WIDTH cycles ->DONE.
  - DONE: if !stall, load outputs from acc, out_valid<=1, ->IDLE, busy=0. If stall, remain in DONE.
- MUL latency WIDTH+1 cycles from accept to out_valid. in_ready=0 outside IDLE.
- flush=1: out_valid<=0 next edge, FSM->IDLE, busy<=0. Overrides stall and a simultaneous in_valid, whose instruction is dropped. Other data regs hold.
- Operand capture occurs only on accept; inputs may change freely otherwise.

Test Plan:
- Reset: drive rst=0 mid-operation -> all outputs 0, busy=0, in_ready=1 after release.
- ADD: aluin1=1, a=0x7FFF, aluin2=2, imm=0x0001 -> next cycle aluout=0x8000, zero=0, pos=0, out_valid=1. SUB a=5, b=5 -> aluout=0, zero=1.
- PC increment: aluin1=0, pc=0x00FE, aluin2=1 -> aluout=0x0100, pos=1. b=0x1234, rd=7 -> bout=0x1234, rdout=7.
- MUL: a=0x0003, b=0xFFFF -> in_ready=0 for 17 cycles, then aluout=0xFFFD, out_valid=1 at cycle 17 (WIDTH=16). SRA 0x8000 by 15 -> 0xFFFF.
- Stall: assert stall with out_valid=1 holding 0x0042 for 3 cycles -> outputs unchanged, in_ready=0. Stall during DONE -> result held until release.
- Flush: flush at cycle 5 of MUL -> busy=0, no out_valid. Flush with in_valid -> instruction dropped, out_valid=0.
